// File: rtl/tm_input_conditioner.sv
// tm_input_conditioner: synchronizes and debounces the Next/Done buttons and the switch word.
// Optional feature: define TM_NEXT_AUTOREPEAT_EN for auto-repeat pulses while Next is held.

// Per-button debounce FSM; pressed is already synchronized and active-high.
//   state        | meaning
//   RELEASED     | button idle, held = 0
//   PRESS_WAIT   | counting consecutive pressed samples
//   PRESSED      | press accepted, held = 1 (optional repeat counter runs here)
//   RELEASE_WAIT | counting consecutive released samples
module tm_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 12500000,
    parameter bit AUTO_REPEAT     = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic pressed,
    output logic pulse,
    output logic held
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RPT_W = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] DB_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_TC = RPT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [RPT_W-1:0] rpt_cnt, rpt_nxt;
    logic             pulse_nxt, held_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= RELEASED;
            cnt     <= '0;
            rpt_cnt <= '0;
            pulse   <= 1'b0;
            held    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rpt_cnt <= rpt_nxt;
            pulse   <= pulse_nxt;
            held    <= held_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        rpt_nxt   = '0;
        pulse_nxt = 1'b0;
        held_nxt  = held;
        case (state)
            RELEASED: begin
                if (pressed) state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_nxt = RELEASED;
                end else if (cnt == DB_TC) begin
                    state_nxt = PRESSED;
                    pulse_nxt = 1'b1;
                    held_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_nxt = RELEASE_WAIT;
                end else if (AUTO_REPEAT) begin
                    // Repeat counter restarts after each repeat pulse.
                    if (rpt_cnt == RPT_TC) pulse_nxt = 1'b1;
                    else                   rpt_nxt   = rpt_cnt + RPT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_nxt = PRESSED;
                end else if (cnt == DB_TC) begin
                    state_nxt = RELEASED;
                    held_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = RELEASED;
        endcase
    end
endmodule

module tm_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DATA_W          = 6,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              next_btn_n,
    input  logic              done_btn_n,
    input  logic [DATA_W-1:0] sw_in,
    output logic              next_pulse,
    output logic              done_pulse,
    output logic              next_held,
    output logic              done_held,
    output logic [DATA_W-1:0] input_data,
    output logic              data_update
);
`ifdef TM_NEXT_AUTOREPEAT_EN
    localparam bit NEXT_REPEAT = 1'b1;
`else
    localparam bit NEXT_REPEAT = 1'b0;
`endif
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] DB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button synchronizers idle at 1 so reset looks like "released".
    logic [1:0]        btn_meta, btn_sync;
    logic [DATA_W-1:0] sw_meta, sw_sync, sw_cand;
    logic [CNT_W-1:0]  sw_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_meta <= 2'b11;
            btn_sync <= 2'b11;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            btn_meta <= {done_btn_n, next_btn_n};
            btn_sync <= btn_meta;
            sw_meta  <= sw_in;
            sw_sync  <= sw_meta;
        end
    end

    tm_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES),
        .AUTO_REPEAT    (NEXT_REPEAT)
    ) u_next (
        .clock  (clock),
        .reset  (reset),
        .pressed(~btn_sync[0]),
        .pulse  (next_pulse),
        .held   (next_held)
    );

    tm_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES),
        .AUTO_REPEAT    (1'b0)
    ) u_done (
        .clock  (clock),
        .reset  (reset),
        .pressed(~btn_sync[1]),
        .pulse  (done_pulse),
        .held   (done_held)
    );

    // Any bit change reloads the candidate and restarts the settle count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_cand     <= '0;
            sw_cnt      <= '0;
            input_data  <= '0;
            data_update <= 1'b0;
        end else begin
            data_update <= 1'b0;
            if (sw_sync != sw_cand) begin
                sw_cand <= sw_sync;
                sw_cnt  <= '0;
            end else if (sw_cand != input_data) begin
                if (sw_cnt == DB_TC) begin
                    input_data  <= sw_cand;
                    data_update <= 1'b1;
                    sw_cnt      <= '0;
                end else begin
                    sw_cnt <= sw_cnt + CNT_W'(1);
                end
            end else begin
                sw_cnt <= '0;
            end
        end
    end
endmodule
